// File: rtl/qrs_pkg.sv
// Shared widths, constants and state encoding for the RR-interval / heart-rate chain.
package qrs_pkg;
    localparam int FS_DEFAULT = 360;
    localparam int ADDR_W     = 32;
    localparam int RR_W       = 16;
    localparam int SUM_W      = 20;
    localparam int HR_NUM     = 60 * FS_DEFAULT;

    typedef enum logic [1:0] {S_FIRST, S_TRACK, S_DIV} state_t;

    function automatic int hr_num(input int fs);
        return 60 * fs;
    endfunction
endpackage

// File: rtl/hr_divider.sv
// 16/16 restoring divider, one quotient bit per cycle; done pulses after the last bit.
module hr_divider
    import qrs_pkg::*;
(
    input  logic            clock_iht,
    input  logic            rst_n,
    input  logic            start,
    input  logic [RR_W-1:0] dividend,
    input  logic [RR_W-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [RR_W-1:0] quotient
);
    logic [RR_W-1:0] quo_q, quo_d, rem_q, rem_d, div_q, div_d;
    logic [4:0]      cnt_q, cnt_d;
    logic            busy_q, busy_d, done_q, done_d;
    logic [RR_W:0]   rem_sh;

    always_comb begin
        quo_d  = quo_q;
        rem_d  = rem_q;
        div_d  = div_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        rem_sh = {rem_q, quo_q[RR_W-1]};
        if (start) begin
            quo_d  = dividend;
            rem_d  = '0;
            div_d  = divisor;
            cnt_d  = 5'(RR_W);
            busy_d = 1'b1;
        end else if (busy_q) begin
            quo_d = {quo_q[RR_W-2:0], 1'b0};
            if (rem_sh >= {1'b0, div_q}) begin
                rem_d    = RR_W'(rem_sh - {1'b0, div_q});
                quo_d[0] = 1'b1;
            end else begin
                rem_d = rem_sh[RR_W-1:0];
            end
            cnt_d = cnt_q - 5'd1;
            if (cnt_q == 5'd1) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock_iht or negedge rst_n) begin
        if (!rst_n) begin
            quo_q  <= '0;
            rem_q  <= '0;
            div_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign quotient = quo_q;
endmodule

// File: rtl/rr_interval_calc.sv
// Turns R-peak sample addresses into RR intervals, a windowed average and heart rate.
// Pipeline: event latch (k) -> classify (k+1) -> buffer/sum/divider load (k+2).
module rr_interval_calc
    import qrs_pkg::*;
#(
    parameter int FS      = FS_DEFAULT,
    parameter int REFRACT = 72,
    parameter int RR_MAX  = 1080,
    parameter int AVG_LEN = 8
) (
    input  logic              clock_iht,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr_R_peak,
    output logic [RR_W-1:0]   rr_interval,
    output logic              rr_valid,
    output logic [7:0]        hr_bpm,
    output logic              hr_valid,
    output logic              irregular,
    output logic              missed_beat,
    output logic [15:0]       reject_cnt
);
    localparam int                PTR_W     = $clog2(AVG_LEN);
    localparam logic [PTR_W:0]    FULL      = (PTR_W+1)'(AVG_LEN);
    localparam logic [RR_W-1:0]   HR_N      = RR_W'(hr_num(FS));
    localparam logic [ADDR_W-1:0] REFRACT_W = ADDR_W'(REFRACT);
    localparam logic [ADDR_W-1:0] RR_MAX_W  = ADDR_W'(RR_MAX);

    state_t state_q, state_d;
    logic [ADDR_W-1:0] addr_q, ev_addr_q, prev_q, prev_d, delta;
    logic              ev_q, event_now;
    logic [RR_W-1:0]   rr_interval_q, rr_interval_d, acc_val_q, acc_val_d;
    logic              rr_valid_q, rr_valid_d, irregular_q, irregular_d;
    logic              missed_q, missed_d, acc_q, acc_d, pend_q, pend_d;
    logic [15:0]       reject_q, reject_d;
    logic [AVG_LEN-1:0][RR_W-1:0] buf_q, buf_d;
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W:0]    fill_q, fill_d;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic [RR_W-1:0]   avg_cur, avg_new, diff;
    logic [7:0]        hr_q, hr_d;
    logic              hr_valid_q, hr_valid_d;
    logic              div_start, div_busy, div_done;
    logic [RR_W-1:0]   div_quo;

    assign event_now = (addr_R_peak != addr_q) && (addr_R_peak != '0);
    assign delta     = ev_addr_q - prev_q;
    assign avg_cur   = RR_W'(sum_q >> PTR_W);
    assign diff      = (delta[RR_W-1:0] > avg_cur) ? delta[RR_W-1:0] - avg_cur
                                                   : avg_cur - delta[RR_W-1:0];

    always_comb begin
        prev_d        = prev_q;
        rr_interval_d = rr_interval_q;
        rr_valid_d    = 1'b0;
        irregular_d   = irregular_q;
        missed_d      = missed_q;
        reject_d      = reject_q;
        acc_d         = 1'b0;
        acc_val_d     = acc_val_q;
        if (ev_q && state_q == S_FIRST) begin
            prev_d = ev_addr_q;
        end else if (ev_q) begin
            if (ev_addr_q <= prev_q) begin
                prev_d = ev_addr_q;
            end else if (delta < REFRACT_W) begin
                if (reject_q != 16'hFFFF) reject_d = reject_q + 16'd1;
            end else if (delta > RR_MAX_W) begin
                prev_d   = ev_addr_q;
                missed_d = 1'b1;
            end else begin
                prev_d        = ev_addr_q;
                rr_interval_d = delta[RR_W-1:0];
                rr_valid_d    = 1'b1;
                missed_d      = 1'b0;
                acc_d         = 1'b1;
                acc_val_d     = delta[RR_W-1:0];
                irregular_d   = (fill_q == FULL) && (diff > (avg_cur >> 2));
            end
        end
    end

    // Window update lands one cycle after the accept so the divider sees the new sum.
    always_comb begin
        buf_d  = buf_q;
        wptr_d = wptr_q;
        fill_d = fill_q;
        sum_d  = sum_q;
        if (acc_q) begin
            buf_d[wptr_q] = acc_val_q;
            wptr_d        = wptr_q + 1'b1;
            sum_d         = sum_q + SUM_W'(acc_val_q) - SUM_W'(buf_q[wptr_q]);
            if (fill_q != FULL) fill_d = fill_q + 1'b1;
        end
    end
    assign avg_new = RR_W'(sum_d >> PTR_W);

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        div_start  = 1'b0;
        hr_d       = hr_q;
        hr_valid_d = 1'b0;
        case (state_q)
            S_FIRST: if (ev_q) state_d = S_TRACK;
            S_TRACK: begin
                if (acc_q && fill_d == FULL && !div_busy) begin
                    div_start = 1'b1;
                    state_d   = S_DIV;
                end
            end
            S_DIV: begin
                if (acc_q) pend_d = 1'b1;
                if (div_done) begin
                    hr_d       = (div_quo > 16'd255) ? 8'd255 : div_quo[7:0];
                    hr_valid_d = 1'b1;
                    // An accept landing on the finishing edge still forces a recompute.
                    if (pend_q || acc_q) begin
                        div_start = 1'b1;
                        pend_d    = 1'b0;
                    end else begin
                        state_d = S_TRACK;
                    end
                end
            end
            default: state_d = S_FIRST;
        endcase
    end

    hr_divider u_div (
        .clock_iht (clock_iht),
        .rst_n     (rst_n),
        .start     (div_start),
        .dividend  (HR_N),
        .divisor   (avg_new),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quo)
    );

    always_ff @(posedge clock_iht or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_FIRST;
            addr_q        <= '0;
            ev_q          <= 1'b0;
            ev_addr_q     <= '0;
            prev_q        <= '0;
            rr_interval_q <= '0;
            rr_valid_q    <= 1'b0;
            irregular_q   <= 1'b0;
            missed_q      <= 1'b0;
            reject_q      <= '0;
            acc_q         <= 1'b0;
            acc_val_q     <= '0;
            buf_q         <= '0;
            wptr_q        <= '0;
            fill_q        <= '0;
            sum_q         <= '0;
            pend_q        <= 1'b0;
            hr_q          <= '0;
            hr_valid_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_R_peak;
            ev_q          <= event_now;
            ev_addr_q     <= addr_R_peak;
            prev_q        <= prev_d;
            rr_interval_q <= rr_interval_d;
            rr_valid_q    <= rr_valid_d;
            irregular_q   <= irregular_d;
            missed_q      <= missed_d;
            reject_q      <= reject_d;
            acc_q         <= acc_d;
            acc_val_q     <= acc_val_d;
            buf_q         <= buf_d;
            wptr_q        <= wptr_d;
            fill_q        <= fill_d;
            sum_q         <= sum_d;
            pend_q        <= pend_d;
            hr_q          <= hr_d;
            hr_valid_q    <= hr_valid_d;
        end
    end

    assign rr_interval = rr_interval_q;
    assign rr_valid    = rr_valid_q;
    assign hr_bpm      = hr_q;
    assign hr_valid    = hr_valid_q;
    assign irregular   = irregular_q;
    assign missed_beat = missed_q;
    assign reject_cnt  = reject_q;
endmodule

// File: tb/tb_rr_interval_calc.sv
// Directed bench: a table of peak addresses with hand-computed outputs, plus
// hand sequences for saturation, refractory boundary and reset mid-divide.
module tb_rr_interval_calc;
    import qrs_pkg::*;

    localparam int WIN = 25;
    localparam int NV  = 25;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr_a, addr_b;
    logic [15:0] rr_interval_a, rr_interval_b, reject_cnt_a, reject_cnt_b;
    logic [7:0]  hr_bpm_a, hr_bpm_b;
    logic        rr_valid_a, rr_valid_b, hr_valid_a, hr_valid_b;
    logic        irregular_a, irregular_b, missed_a, missed_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rr_interval_calc dut_a (
        .clock_iht (clk), .rst_n (rst_n), .addr_R_peak (addr_a),
        .rr_interval (rr_interval_a), .rr_valid (rr_valid_a),
        .hr_bpm (hr_bpm_a), .hr_valid (hr_valid_a),
        .irregular (irregular_a), .missed_beat (missed_a), .reject_cnt (reject_cnt_a)
    );

    rr_interval_calc #(.REFRACT(40)) dut_b (
        .clock_iht (clk), .rst_n (rst_n), .addr_R_peak (addr_b),
        .rr_interval (rr_interval_b), .rr_valid (rr_valid_b),
        .hr_bpm (hr_bpm_b), .hr_valid (hr_valid_b),
        .irregular (irregular_b), .missed_beat (missed_b), .reject_cnt (reject_cnt_b)
    );

    typedef struct {
        logic [31:0] addr;
        int          rr_n;
        logic [15:0] rr;
        int          hr_n;
        logic [7:0]  hr;
        logic        irr;
        logic        miss;
        logic [15:0] rej;
    } vec_t;

    vec_t tbl [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic run_win(input logic [31:0] a, input bit on_b,
                           output int rr_n, output int rr_at, output logic [15:0] rr_v,
                           output int hr_n, output int hr_at, output logic [7:0] hr_v);
        rr_n = 0; rr_at = -1; rr_v = '0;
        hr_n = 0; hr_at = -1; hr_v = '0;
        if (on_b) addr_b = a; else addr_a = a;
        for (int i = 1; i <= WIN; i++) begin
            @(negedge clk);
            if (on_b ? rr_valid_b : rr_valid_a) begin
                rr_n++; rr_at = i; rr_v = on_b ? rr_interval_b : rr_interval_a;
            end
            if (on_b ? hr_valid_b : hr_valid_a) begin
                hr_n++; hr_at = i; hr_v = on_b ? hr_bpm_b : hr_bpm_a;
            end
        end
    endtask

    initial begin
        int          rr_n, rr_at, hr_n, hr_at, idx;
        logic [15:0] rr_v;
        logic [7:0]  hr_v;
        logic [7:0]  hr180 [9];
        logic        irr180 [9];

        hr180  = '{8'd64, 8'd68, 8'd73, 8'd80, 8'd87, 8'd96, 8'd106, 8'd120, 8'd120};
        irr180 = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

        tbl[0] = '{32'd1000, 0, 16'd0, 0, 8'd0, 1'b0, 1'b0, 16'd0};
        for (int i = 1; i <= 7; i++)
            tbl[i] = '{32'(1000 + 360 * i), 1, 16'd360, 0, 8'd0, 1'b0, 1'b0, 16'd0};
        tbl[8]  = '{32'd3880, 1, 16'd360, 1, 8'd60, 1'b0, 1'b0, 16'd0};
        tbl[9]  = '{32'd4240, 1, 16'd360, 1, 8'd60, 1'b0, 1'b0, 16'd0};
        tbl[10] = '{32'd4290, 0, 16'd0,   0, 8'd0,  1'b0, 1'b0, 16'd1};
        tbl[11] = '{32'd4600, 1, 16'd360, 1, 8'd60, 1'b0, 1'b0, 16'd1};
        tbl[12] = '{32'd6600, 0, 16'd0,   0, 8'd0,  1'b0, 1'b1, 16'd1};
        tbl[13] = '{32'd6960, 1, 16'd360, 1, 8'd60, 1'b0, 1'b0, 16'd1};
        for (int j = 0; j < 9; j++)
            tbl[14 + j] = '{32'(7140 + 180 * j), 1, 16'd180, 1, hr180[j], irr180[j], 1'b0, 16'd1};
        tbl[23] = '{32'd8880, 1, 16'd300, 1, 8'd110, 1'b1, 1'b0, 16'd1};
        tbl[24] = '{32'd9060, 1, 16'd180, 1, 8'd110, 1'b0, 1'b0, 16'd1};

        rst_n = 1'b0; addr_a = '0; addr_b = '0;
        repeat (3) @(negedge clk);
        chk("rst_rr_interval", 32'(rr_interval_a), 32'd0);
        chk("rst_rr_valid", 32'(rr_valid_a), 32'd0);
        chk("rst_hr_bpm", 32'(hr_bpm_a), 32'd0);
        chk("rst_hr_valid", 32'(hr_valid_a), 32'd0);
        chk("rst_irregular", 32'(irregular_a), 32'd0);
        chk("rst_missed", 32'(missed_a), 32'd0);
        chk("rst_reject", 32'(reject_cnt_a), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < NV; v++) begin
            run_win(tbl[v].addr, 1'b0, rr_n, rr_at, rr_v, hr_n, hr_at, hr_v);
            chk($sformatf("v%0d_rr_count", v), 32'(rr_n), 32'(tbl[v].rr_n));
            if (tbl[v].rr_n == 1) begin
                chk($sformatf("v%0d_rr_value", v), 32'(rr_v), 32'(tbl[v].rr));
                chk($sformatf("v%0d_rr_latency", v), 32'(rr_at), 32'd2);
            end
            chk($sformatf("v%0d_hr_count", v), 32'(hr_n), 32'(tbl[v].hr_n));
            if (tbl[v].hr_n == 1) begin
                chk($sformatf("v%0d_hr_value", v), 32'(hr_v), 32'(tbl[v].hr));
                chk($sformatf("v%0d_hr_after_rr", v), 32'(hr_at - rr_at), 32'd18);
            end
            chk($sformatf("v%0d_irregular", v), 32'(irregular_a), 32'(tbl[v].irr));
            chk($sformatf("v%0d_missed", v), 32'(missed_a), 32'(tbl[v].miss));
            chk($sformatf("v%0d_reject", v), 32'(reject_cnt_a), 32'(tbl[v].rej));
        end

        // REFRACT lowered to 40: 80-sample spacing saturates the rate at 255.
        for (int n = 0; n < 9; n++) begin
            run_win(32'(1000 + 80 * n), 1'b1, rr_n, rr_at, rr_v, hr_n, hr_at, hr_v);
            if (n > 0) chk($sformatf("b%0d_rr_value", n), 32'(rr_v), 32'd80);
        end
        chk("b_hr_count", 32'(hr_n), 32'd1);
        chk("b_hr_saturated", 32'(hr_v), 32'd255);
        chk("b_hr_bpm_port", 32'(hr_bpm_b), 32'd255);
        run_win(32'd1679, 1'b1, rr_n, rr_at, rr_v, hr_n, hr_at, hr_v);
        chk("b_refract_minus1_rr", 32'(rr_n), 32'd0);
        chk("b_refract_minus1_rej", 32'(reject_cnt_b), 32'd1);
        run_win(32'd1680, 1'b1, rr_n, rr_at, rr_v, hr_n, hr_at, hr_v);
        chk("b_refract_exact_rr", 32'(rr_n), 32'd1);
        chk("b_refract_exact_val", 32'(rr_v), 32'd40);

        // Reset five iterations into a divide.
        addr_a = 32'd9240;
        repeat (8) @(negedge clk);
        rst_n  = 1'b0;
        addr_a = '0;
        #1;
        chk("mid_rst_rr_interval", 32'(rr_interval_a), 32'd0);
        chk("mid_rst_hr_bpm", 32'(hr_bpm_a), 32'd0);
        chk("mid_rst_irregular", 32'(irregular_a), 32'd0);
        chk("mid_rst_missed", 32'(missed_a), 32'd0);
        chk("mid_rst_reject", 32'(reject_cnt_a), 32'd0);
        chk("mid_rst_state", 32'(dut_a.state_q), 32'(S_FIRST));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idx = 0;
        for (int i = 0; i < WIN; i++) begin
            @(negedge clk);
            if (hr_valid_a || rr_valid_a) idx++;
        end
        chk("post_rst_no_pulse", 32'(idx), 32'd0);
        chk("post_rst_hr_bpm", 32'(hr_bpm_a), 32'd0);
        chk("post_rst_state", 32'(dut_a.state_q), 32'(S_FIRST));
        run_win(32'd10000, 1'b0, rr_n, rr_at, rr_v, hr_n, hr_at, hr_v);
        chk("post_rst_first_rr", 32'(rr_n), 32'd0);
        run_win(32'd10360, 1'b0, rr_n, rr_at, rr_v, hr_n, hr_at, hr_v);
        chk("post_rst_second_rr", 32'(rr_n), 32'd1);
        chk("post_rst_second_val", 32'(rr_v), 32'd360);
        chk("post_rst_second_hr", 32'(hr_n), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
